// File: rtl/bcd_scan_display.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with frame-synchronous shadow digits.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module bcd_scan_display #(
   parameter int CLK_DIV = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] d4,
   input  logic [3:0] dp_mask,
   input  logic       blank,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   localparam logic [1:0] S0 = 2'd0;
   localparam logic [1:0] S1 = 2'd1;
   localparam logic [1:0] S2 = 2'd2;
   localparam logic [1:0] S3 = 2'd3;

   logic [CW-1:0]   count;
   logic [1:0]      idx;
   logic [1:0]      idx_next;
   logic [3:0][3:0] sh_digit;
   logic [3:0]      sh_dp;
   logic            load_pending;
   logic            tick;
   logic            load;
   logic [3:0]      suppress;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   assign tick = (count == LAST);
   // The shadow reloads at each frame boundary and once right after reset so frame one is valid.
   assign load = load_pending | (tick & (idx == S3));

   always_comb begin
      idx_next = idx;
      if (tick) begin
         case (idx)
            S0:      idx_next = S1;
            S1:      idx_next = S2;
            S2:      idx_next = S3;
            default: idx_next = S0;
         endcase
      end
   end

   always_comb begin
      suppress = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
      suppress[3] = (sh_digit[3] == 4'd0) & ~sh_dp[3];
      suppress[2] = (sh_digit[3] == 4'd0) & (sh_digit[2] == 4'd0) & ~sh_dp[2];
      suppress[1] = (sh_digit[3] == 4'd0) & (sh_digit[2] == 4'd0) &
                    (sh_digit[1] == 4'd0) & ~sh_dp[1];
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count        <= '0;
         idx          <= S0;
         sh_digit     <= '0;
         sh_dp        <= 4'b0000;
         load_pending <= 1'b1;
         frame_start  <= 1'b0;
         an           <= 4'b1111;
         seg          <= 7'b1111111;
         dp           <= 1'b1;
      end else begin
         count        <= tick ? '0 : count + 1'b1;
         idx          <= idx_next;
         load_pending <= 1'b0;
         if (load) begin
            sh_digit <= {d4, d3, d2, d1};
            sh_dp    <= dp_mask;
         end
         frame_start  <= load;
         an           <= (blank | suppress[idx]) ? 4'b1111 : ~(4'b0001 << idx);
         seg          <= decode(sh_digit[idx]);
         dp           <= ~sh_dp[idx];
      end
   end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display at CLK_DIV=4; edge numbers count from the first reset edge.
module tb_bcd_scan_display;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] d1, d2, d3, d4, dp_mask;
   logic       blank;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_start;

   int checks = 0;
   int errors = 0;
   int edgeNum = -1;

   bcd_scan_display #(.CLK_DIV(4)) dut (
      .clk(clk), .reset(reset), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
      .dp_mask(dp_mask), .blank(blank), .an(an), .seg(seg), .dp(dp),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         edgeNum++;
      end
   endtask

   task automatic goTo(input int k);
      if (edgeNum < k) applyStimulus(k - edgeNum);
   endtask

   task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s edge %0d observed %b expected %b", tag, edgeNum, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; blank = 1'b0; dp_mask = 4'b0000;
      d4 = 4'd1; d3 = 4'd2; d2 = 4'd3; d1 = 4'd4;

      goTo(0);
      checkOutput("rst_an",  {3'b0, an},          7'b0001111);
      checkOutput("rst_seg", seg,                 7'b1111111);
      checkOutput("rst_dp",  {6'b0, dp},          7'd1);
      checkOutput("rst_fs",  {6'b0, frame_start}, 7'd0);
      reset = 1'b0;

      goTo(1);
      checkOutput("t1_an0", {3'b0, an},          7'b0001110);
      checkOutput("t1_fs",  {6'b0, frame_start}, 7'd1);
      goTo(2);
      checkOutput("t1_seg0", seg,                 7'b0011001);
      checkOutput("t1_fs0",  {6'b0, frame_start}, 7'd0);
      goTo(4);
      checkOutput("t1_an0end", {3'b0, an}, 7'b0001110);
      goTo(5);
      checkOutput("t1_an1",  {3'b0, an}, 7'b0001101);
      checkOutput("t1_seg1", seg,        7'b0110000);
      goTo(9);
      checkOutput("t1_an2",  {3'b0, an}, 7'b0001011);
      checkOutput("t1_seg2", seg,        7'b0100100);
      goTo(13);
      checkOutput("t1_an3",  {3'b0, an}, 7'b0000111);
      checkOutput("t1_seg3", seg,        7'b1111001);
      d4 = 4'd0; d3 = 4'd0; d2 = 4'd0; d1 = 4'd5;

      goTo(16);
      checkOutput("t2_fs",    {6'b0, frame_start}, 7'd1);
      checkOutput("t2_an3hd", {3'b0, an},          7'b0000111);
      goTo(17);
      checkOutput("t2_an0",  {3'b0, an}, 7'b0001110);
      checkOutput("t2_seg0", seg,        7'b0010010);
      goTo(18);
      d1 = 4'd6;
      goTo(20);
      checkOutput("t2_hold5", seg, 7'b0010010);
      goTo(21);
      checkOutput("t2_seg1", seg, 7'b1000000);
      goTo(31);
      checkOutput("t2_nofs", {6'b0, frame_start}, 7'd0);
      goTo(33);
      checkOutput("t2_an0new",  {3'b0, an}, 7'b0001110);
      checkOutput("t2_seg0new", seg,        7'b0000010);

      goTo(40);
      d1 = 4'hC; d2 = 4'd9;
      goTo(49);
      checkOutput("t3_dash", seg, 7'b0111111);
      goTo(53);
      checkOutput("t3_an1",  {3'b0, an}, 7'b0001101);
      checkOutput("t3_seg9", seg,        7'b0010000);
      goTo(57);
      checkOutput("t3_seg0", seg, 7'b1000000);
      dp_mask = 4'b0100;

      goTo(65);
      checkOutput("t4_dp_s0", {6'b0, dp}, 7'd1);
      goTo(69);
      checkOutput("t4_dp_s1", {6'b0, dp}, 7'd1);
      goTo(73);
      checkOutput("t4_an_s2", {3'b0, an}, 7'b0001011);
      checkOutput("t4_dp_s2", {6'b0, dp}, 7'd0);
      goTo(77);
      checkOutput("t4_dp_s3", {6'b0, dp}, 7'd1);
      goTo(81);
      blank = 1'b1;
      goTo(82);
      checkOutput("t4_blank_first", {3'b0, an}, 7'b0001111);
      goTo(90);
      checkOutput("t4_blank_an",  {3'b0, an}, 7'b0001111);
      checkOutput("t4_blank_dp",  {6'b0, dp}, 7'd0);
      checkOutput("t4_blank_seg", seg,        7'b1000000);
      goTo(91);
      checkOutput("t4_blank_last", {3'b0, an}, 7'b0001111);
      blank = 1'b0;
      goTo(92);
      checkOutput("t4_unblank_an", {3'b0, an}, 7'b0001011);
      goTo(93);
      checkOutput("t4_idx_adv", {3'b0, an}, 7'b0000111);

      goTo(105);
      checkOutput("t5_pre_an", {3'b0, an}, 7'b0001011);
      reset = 1'b1;
      goTo(106);
      checkOutput("t5_rst_an",  {3'b0, an}, 7'b0001111);
      checkOutput("t5_rst_seg", seg,        7'b1111111);
      checkOutput("t5_rst_dp",  {6'b0, dp}, 7'd1);
      reset = 1'b0;
      goTo(107);
      checkOutput("t5_an0", {3'b0, an},          7'b0001110);
      checkOutput("t5_fs",  {6'b0, frame_start}, 7'd1);
      checkOutput("t5_dp0", {6'b0, dp},          7'd1);
      goTo(108);
      checkOutput("t5_seg0", seg, 7'b0111111);
      goTo(110);
      checkOutput("t5_an0end", {3'b0, an}, 7'b0001110);
      goTo(111);
      checkOutput("t5_an1",  {3'b0, an}, 7'b0001101);
      checkOutput("t5_seg1", seg,        7'b0010000);
      goTo(115);
      checkOutput("t5_an2", {3'b0, an}, 7'b0001011);
      checkOutput("t5_dp2", {6'b0, dp}, 7'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
